mem_wb_stage: RTL and testbench

// - MEM/WB pipeline register plus writeback select for the 5-stage MIPS pipeline.
// - Captures MEM-stage control/data each cycle; drives the register-file write port.
// - Sits directly downstream of the memory stage; the write port also feeds the forwarding unit.
// - Provides stall/flush bubble control and a retired-instruction counter.

---
 rtl/mem_wb_stage_pkg.sv | 16 +
 rtl/mem_wb_stage_wb_select.sv | 34 +++
 rtl/mem_wb_stage.sv | 101 ++++++++++
 tb/tb_mem_wb_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB writeback path: destination and data selects.
package mem_wb_stage_pkg;

  // Destination register select (cregwa)
  localparam logic WA_RT = 1'b0;
  localparam logic WA_RD = 1'b1;

  // Writeback data select (cregwd); 2'b11 is reserved and writes zero
  typedef enum logic [1:0] {
    WD_ALUOUT = 2'b00,
    WD_MEMRD  = 2'b01,
    WD_PC8    = 2'b10,
    WD_RSVD   = 2'b11
  } wd_sel_e;

endpackage

// File: rtl/mem_wb_stage_wb_select.sv
// Combinational writeback select: picks the destination register and the
// write data. Shared with the forwarding unit for its MEM-stage preview.
module wb_select
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_OFFSET = 8
) (
  input  logic              cregwa,
  input  logic [1:0]        cregwd,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memrd,
  input  logic [DATA_W-1:0] pc,
  output logic [REG_AW-1:0] wa,
  output logic [DATA_W-1:0] wd
);

  assign wa = (cregwa == WA_RD) ? rd : rt;

  // Data mux; link address wraps naturally at DATA_W bits
  always_comb begin
    wd = '0;
    case (wd_sel_e'(cregwd))
      WD_ALUOUT: wd = aluout;
      WD_MEMRD:  wd = memrd;
      WD_PC8:    wd = pc + DATA_W'(LINK_OFFSET);
      default:   wd = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with flush/stall bubble control, register-file
// write port and a retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int LINK_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              cregwa_i,
  input  logic [1:0]        cregwd_i,
  input  logic              regwe_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [DATA_W-1:0] aluout_i,
  input  logic [DATA_W-1:0] memrd_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic              we_wb,
  output logic [REG_AW-1:0] wa_wb,
  output logic [DATA_W-1:0] wd_wb,
  output logic              valid_o,
  output logic [CNT_W-1:0]  retired_o
);

  logic              valid_q, regwe_q, cregwa_q;
  logic [1:0]        cregwd_q;
  logic [REG_AW-1:0] rt_q, rd_q;
  logic [DATA_W-1:0] aluout_q, memrd_q, pc_q;
  logic [CNT_W-1:0]  retired_q;

  // WB register capture: flush beats stall beats load; a flush zeroes every field
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      regwe_q  <= 1'b0;
      cregwa_q <= 1'b0;
      cregwd_q <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      aluout_q <= '0;
      memrd_q  <= '0;
      pc_q     <= '0;
    end else if (flush_i) begin
      valid_q  <= 1'b0;
      regwe_q  <= 1'b0;
      cregwa_q <= 1'b0;
      cregwd_q <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      aluout_q <= '0;
      memrd_q  <= '0;
      pc_q     <= '0;
    end else if (!stall_i) begin
      valid_q  <= valid_i;
      regwe_q  <= regwe_i;
      cregwa_q <= cregwa_i;
      cregwd_q <= cregwd_i;
      rt_q     <= rt_i;
      rd_q     <= rd_i;
      aluout_q <= aluout_i;
      memrd_q  <= memrd_i;
      pc_q     <= pc_i;
    end
  end

  // Retire counter: the WB occupant retires when it advances; a flushed one is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retired_q <= '0;
    else if (valid_q && !stall_i && !flush_i)
      retired_q <= retired_q + 1'b1;
  end

  wb_select #(
    .DATA_W     (DATA_W),
    .REG_AW     (REG_AW),
    .LINK_OFFSET(LINK_OFFSET)
  ) u_sel (
    .cregwa (cregwa_q),
    .cregwd (cregwd_q),
    .rt     (rt_q),
    .rd     (rd_q),
    .aluout (aluout_q),
    .memrd  (memrd_q),
    .pc     (pc_q),
    .wa     (wa_wb),
    .wd     (wd_wb)
  );

  // Writes to $0 never reach the register file
  assign we_wb     = valid_q & regwe_q & (wa_wb != '0);
  assign valid_o   = valid_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage with a behavioural slot model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 0, flush_i = 0, valid_i = 0, cregwa_i = 0, regwe_i = 0;
  logic [1:0]  cregwd_i = 0;
  logic [4:0]  rt_i = 0, rd_i = 0;
  logic [31:0] aluout_i = 0, memrd_i = 0, pc_i = 0;

  logic        we_wb, valid_o, we_s, valid_s;
  logic [4:0]  wa_wb, wa_s;
  logic [31:0] wd_wb, wd_s, retired_o;
  logic [3:0]  retired_s;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .cregwa_i(cregwa_i), .cregwd_i(cregwd_i), .regwe_i(regwe_i), .rt_i(rt_i), .rd_i(rd_i),
    .aluout_i(aluout_i), .memrd_i(memrd_i), .pc_i(pc_i),
    .we_wb(we_wb), .wa_wb(wa_wb), .wd_wb(wd_wb), .valid_o(valid_o), .retired_o(retired_o)
  );

  // Narrow-counter instance on the same stimulus, to exercise wrap-around
  mem_wb_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .cregwa_i(cregwa_i), .cregwd_i(cregwd_i), .regwe_i(regwe_i), .rt_i(rt_i), .rd_i(rd_i),
    .aluout_i(aluout_i), .memrd_i(memrd_i), .pc_i(pc_i),
    .we_wb(we_s), .wa_wb(wa_s), .wd_wb(wd_s), .valid_o(valid_s), .retired_o(retired_s)
  );

  // Model: what instruction sits in WB, and how many have retired
  typedef struct {
    bit v, we, sel_rd;
    bit [1:0] dsel;
    bit [4:0] rt, rd;
    bit [31:0] alu, mem, pc;
  } slot_t;

  slot_t m;
  bit [31:0] m_cnt;
  bit [3:0]  m_cnt_s;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    m = '{default: 0};
    m_cnt = 0;
    m_cnt_s = 0;
  endfunction

  // Effect of one rising edge on the model
  function automatic void m_edge();
    if (!rst) begin
      m_clear();
      return;
    end
    if (m.v && !stall_i && !flush_i) begin
      m_cnt++;
      m_cnt_s++;
    end
    if (flush_i) m = '{default: 0};
    else if (!stall_i)
      m = '{v: valid_i, we: regwe_i, sel_rd: cregwa_i, dsel: cregwd_i, rt: rt_i, rd: rd_i,
            alu: aluout_i, mem: memrd_i, pc: pc_i};
  endfunction

  function automatic bit [4:0] m_wa();
    return m.sel_rd ? m.rd : m.rt;
  endfunction

  function automatic bit [31:0] m_wd();
    case (m.dsel)
      2'd0: return m.alu;
      2'd1: return m.mem;
      2'd2: return m.pc + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  task automatic compare_all();
    chk("valid_o", valid_o, m.v);
    chk("we_wb", we_wb, m.v && m.we && m_wa() != 0);
    chk("wa_wb", wa_wb, m_wa());
    chk("wd_wb", wd_wb, m_wd());
    chk("retired_o", retired_o, m_cnt);
    chk("retired_s", retired_s, m_cnt_s);
    chk("we_s", we_s, we_wb);
    chk("wd_s", wd_s, wd_wb);
  endtask

  // One clock: edge updates the model, outputs are compared at the falling edge
  task automatic cycle();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input bit we, input bit sel_rd, input bit [1:0] ds,
                       input bit [4:0] rt, input bit [4:0] rd,
                       input bit [31:0] alu, input bit [31:0] mem, input bit [31:0] pc);
    valid_i = v; regwe_i = we; cregwa_i = sel_rd; cregwd_i = ds;
    rt_i = rt; rd_i = rd; aluout_i = alu; memrd_i = mem; pc_i = pc;
  endtask

  bit [31:0] r0;

  initial begin
    m_clear();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_valid", valid_o, 0);
    chk("rst_we", we_wb, 0);
    chk("rst_cnt", retired_o, 0);
    rst = 1'b1;

    // Directed: aluout to rd
    drive(1, 1, 1, 2'b00, 5'd0, 5'd5, 32'h1234, 32'h0, 32'h0);
    cycle();
    chk("t1_we", we_wb, 1);
    chk("t1_wa", wa_wb, 5);
    chk("t1_wd", wd_wb, 32'h1234);
    chk("t1_cnt0", retired_o, 0);
    // memrd to rt
    drive(1, 1, 0, 2'b01, 5'd9, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
    cycle();
    chk("t1_cnt1", retired_o, 1);
    chk("t2_wa", wa_wb, 9);
    chk("t2_wd", wd_wb, 32'hDEADBEEF);
    // link address
    drive(1, 1, 0, 2'b10, 5'd31, 5'd0, 32'h0, 32'h0, 32'h00400010);
    cycle();
    chk("t2_pc8", wd_wb, 32'h00400018);
    // write to $0 suppressed but still retires
    drive(1, 1, 1, 2'b00, 5'd4, 5'd0, 32'h77, 32'h0, 32'h0);
    cycle();
    chk("t3_we0", we_wb, 0);
    drive(0, 0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("t3_cnt", retired_o, 4);

    // Stall holds contents and freezes the counter
    drive(1, 1, 1, 2'b00, 5'd0, 5'd7, 32'hAAAA, 32'h0, 32'h0);
    cycle();
    r0 = retired_o;
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 2'b01, 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      cycle();
      chk("t4_we", we_wb, 1);
      chk("t4_wa", wa_wb, 7);
      chk("t4_wd", wd_wb, 32'hAAAA);
      chk("t4_cnt", retired_o, r0);
    end
    flush_i = 1;
    cycle();
    chk("t4_fl_valid", valid_o, 0);
    chk("t4_fl_we", we_wb, 0);
    chk("t4_fl_cnt", retired_o, r0);
    stall_i = 0; flush_i = 0;

    // Async reset between edges
    drive(1, 1, 1, 2'b00, 5'd0, 5'd3, 32'h55, 32'h0, 32'h0);
    cycle();
    chk("t5_pre_we", we_wb, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_we", we_wb, 0);
    chk("t5_valid", valid_o, 0);
    chk("t5_cnt", retired_o, 0);
    m_clear();
    @(negedge clk);
    rst = 1'b1;

    // 16 retirements: narrow counter wraps to 0; reserved data select writes 0
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 1, 2'b11, 5'd0, 5'd1 + 5'(i % 30), $urandom | 32'h1, $urandom, $urandom);
      cycle();
      chk("t6_wd_rsvd", wd_wb, 0);
    end
    chk("t6_wrap_s", retired_s, 0);
    chk("t6_cnt", retired_o, 16);

    // Random traffic, with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      if (!rst) m_clear();
      stall_i = ($urandom_range(0, 99) < 20);
      flush_i = ($urandom_range(0, 99) < 10);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
